// File: rtl/alu_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial alu sequencer.
// Holds the state encoding, the alu opcode values and the NIBBLES range check.
package alu_nibble_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] ALU_PASS_A = 2'b00;
  localparam logic [1:0] ALU_SUB_AB = 2'b01;
  localparam logic [1:0] ALU_ADD_AB = 2'b10;
  localparam logic [1:0] ALU_DEC_A  = 2'b11;

  // Wide enough for the largest legal NIBBLES (8).
  localparam int IDX_W = 3;

  function automatic bit nibbles_ok(input int n);
    return (n >= 1) && (n <= 8);
  endfunction

endpackage

// File: rtl/alu_nibble_seq_nib_sel.sv
// Combinational 4-bit slice selector: nib_o = bus_i[4*idx_i +: 4].
// Indices beyond the bus width return zero.
module alu_nibble_seq_nib_sel #(
  parameter int NIBBLES = 4,
  parameter int IDX_W   = 3
) (
  input  logic [4*NIBBLES-1:0] bus_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [3:0]           nib_o
);

  always_comb begin
    nib_o = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_i == IDX_W'(i)) nib_o = bus_i[4*i +: 4];
    end
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Feeds a 4-bit alu one nibble per cycle (LSB first); done pulses NIBBLES+1 cycles after start, start ignored unless IDLE.
// Defining ALU_SEQ_OVF_EN adds the registered signed-overflow output ovf.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op_l,
  input  logic [1:0]   op_code,
  input  logic         cin,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         zero,
`ifdef ALU_SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cin,
  output logic [1:0]   alu_op,
  output logic         alu_l,
  input  logic [3:0]   alu_r,
  input  logic         alu_cout,
  input  logic         alu_zero
);

  if (!nibbles_ok(NIBBLES)) begin : g_bad_nibbles
    $error("alu_nibble_seq: NIBBLES must be in 1..8");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [1:0]       op_code_q, op_code_d;
  logic             op_l_q, op_l_d, cin_q, cin_d, carry_q, carry_d;
  logic             zacc_q, zacc_d, zero_q, zero_d, c_out_q, c_out_d;
  logic             last_nib;
`ifdef ALU_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_nib) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
    alu_op  = op_code_q;
    alu_l   = op_l_q;
    alu_cin = 1'b0;
    if (state_q == ST_RUN && !op_l_q) alu_cin = (idx_q == '0) ? cin_q : carry_q;
  end

  // idx returns to 0 on RUN exit so IDLE/DONE present nibble 0 to the alu.
  alu_nibble_seq_nib_sel #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_sel_a (
    .bus_i (opa_q),
    .idx_i (idx_q),
    .nib_o (alu_a)
  );

  alu_nibble_seq_nib_sel #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_sel_b (
    .bus_i (opb_q),
    .idx_i (idx_q),
    .nib_o (alu_b)
  );

  always_comb begin
    idx_d     = idx_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_code_d = op_code_q;
    op_l_d    = op_l_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    zacc_d    = zacc_q;
    result_d  = result_q;
    c_out_d   = c_out_q;
    zero_d    = zero_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d     = opa;
          opb_d     = opb;
          op_code_d = op_code;
          op_l_d    = op_l;
          cin_d     = cin;
          idx_d     = '0;
          zacc_d    = 1'b1;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) result_d[4*i +: 4] = alu_r;
        end
        carry_d = alu_cout;
        zacc_d  = zacc_q & alu_zero;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib) begin
          idx_d   = '0;
          c_out_d = ~op_l_q & alu_cout;
          zero_d  = zacc_q & alu_zero;
`ifdef ALU_SEQ_OVF_EN
          ovf_d   = ~op_l_q & (op_code_q == ALU_ADD_AB) &
                    (opa_q[W-1] == opb_q[W-1]) & (alu_r[3] != opa_q[W-1]);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_code_q <= '0;
      op_l_q    <= 1'b0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b1;
      result_q  <= '0;
      c_out_q   <= 1'b0;
      zero_q    <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      idx_q     <= idx_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_code_q <= op_code_d;
      op_l_q    <= op_l_d;
      cin_q     <= cin_d;
      carry_q   <= carry_d;
      zacc_q    <= zacc_d;
      result_q  <= result_d;
      c_out_q   <= c_out_d;
      zero_q    <= zero_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
`ifdef ALU_SEQ_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq (NIBBLES = 4) paired with a behavioural 4-bit alu.
module tb_alu_nibble_seq;

  logic        clk = 1'b0;
  logic        reset, start, op_l, cin;
  logic [1:0]  op_code;
  logic [15:0] opa, opb, result;
  logic        busy, done, c_out, zero;
  logic [3:0]  alu_a, alu_b, alu_r;
  logic        alu_cin, alu_l, alu_cout, alu_zero;
  logic [1:0]  alu_op;
`ifdef ALU_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_l     (op_l),
    .op_code  (op_code),
    .cin      (cin),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .zero     (zero),
`ifdef ALU_SEQ_OVF_EN
    .ovf      (ovf),
`endif
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_op   (alu_op),
    .alu_l    (alu_l),
    .alu_r    (alu_r),
    .alu_cout (alu_cout),
    .alu_zero (alu_zero)
  );

  // 4-bit alu: arithmetic A+B', B' = 0 / ~B / B / F; logic AND / OR / XOR / NOT A.
  function automatic logic [4:0] alu4(input logic l, input logic [1:0] op,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic c);
    logic [3:0] bb;
    logic [4:0] res;
    bb  = 4'h0;
    res = 5'h0;
    if (!l) begin
      case (op)
        2'b00: bb = 4'h0;
        2'b01: bb = ~b;
        2'b10: bb = b;
        default: bb = 4'hF;
      endcase
      res = {1'b0, a} + {1'b0, bb} + {4'h0, c};
    end else begin
      case (op)
        2'b00: res = {1'b0, a & b};
        2'b01: res = {1'b0, a | b};
        2'b10: res = {1'b0, a ^ b};
        default: res = {1'b0, ~a};
      endcase
    end
    return res;
  endfunction

  assign {alu_cout, alu_r} = alu4(alu_l, alu_op, alu_a, alu_b, alu_cin);
  assign alu_zero = (alu_r == 4'h0);

  // Whole-word reference: {cout, zero, result}.
  function automatic logic [17:0] ref_op(input logic l, input logic [1:0] code,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic c);
    logic [16:0] s;
    logic [15:0] r;
    logic        co;
    s  = 17'h0;
    r  = 16'h0;
    co = 1'b0;
    if (!l) begin
      case (code)
        2'b00: s = {1'b0, a} + 17'(c);
        2'b01: s = {1'b0, a} + {1'b0, ~b} + 17'(c);
        2'b10: s = {1'b0, a} + {1'b0, b} + 17'(c);
        default: s = {1'b0, a} + 17'h0FFFF + 17'(c);
      endcase
      r  = s[15:0];
      co = s[16];
    end else begin
      case (code)
        2'b00: r = a & b;
        2'b01: r = a | b;
        2'b10: r = a ^ b;
        default: r = ~a;
      endcase
    end
    return {co, (r == 16'h0), r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int busy_cyc;
  bit got_done;

  // Launch one operation and wait (bounded) for done; optionally scramble inputs mid-run.
  task automatic run_op(input logic l, input logic [1:0] code, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input bit scramble);
    op_l = l; op_code = code; opa = a; opb = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      op_l = 1'($urandom); op_code = 2'($urandom); cin = 1'($urandom);
      opa = 16'($urandom); opb = 16'($urandom);
    end
    busy_cyc = 0;
    got_done = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) busy_cyc++;
        if (l && busy) chk("logic_alu_cin", alu_cin, 0);
        tick();
      end
    end
    chk("done_seen", got_done, 1);
  endtask

  typedef struct {
    logic        l;
    logic [1:0]  code;
    logic [15:0] a, b;
    logic        c;
    logic [15:0] r;
    logic        co, z;
  } vec_t;

  vec_t vecs[8];
  logic [17:0] m;
  int ndone;

  initial begin
    vecs[0] = '{1'b0, 2'b10, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'b10, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 2'b10, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'b01, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'b00, 16'h1234, 16'h1111, 1'b1, 16'h1010, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 2'b01, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 2'b10, 16'hF0F0, 16'hF0F0, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 2'b11, 16'h00FF, 16'h5A5A, 1'b1, 16'hFF00, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; op_l = 1'b0; op_code = 2'b00; cin = 1'b0;
    opa = 16'h0; opb = 16'h0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_zero", zero, 1);
    chk("rst_cout", c_out, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].l, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0);
      chk("vec_latency", busy_cyc, 4);
      chk("vec_result", result, vecs[i].r);
      chk("vec_cout", c_out, vecs[i].co);
      chk("vec_zero", zero, vecs[i].z);
      tick();
      chk("vec_done_1cyc", done, 0);
      chk("vec_result_held", result, vecs[i].r);
    end

    for (int n = 0; n < 150; n++) begin
      logic        rl, rc;
      logic [1:0]  rcode;
      logic [15:0] ra, rb;
      rl = 1'($urandom); rc = 1'($urandom); rcode = 2'($urandom);
      ra = 16'($urandom); rb = 16'($urandom);
      if (n % 8 == 0) rb = 16'hFFFF - ra;
      m = ref_op(rl, rcode, ra, rb, rc);
      run_op(rl, rcode, ra, rb, rc, 1'b1);
      chk("rnd_result", result, m[15:0]);
      chk("rnd_zero", zero, m[16]);
      chk("rnd_cout", c_out, m[17]);
      tick();
    end

    // start pulsed in the first RUN cycle and again in DONE must be ignored.
    op_l = 1'b0; op_code = 2'b10; opa = 16'h00FF; opb = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) ndone++;
      start = (k == 0) || done;
      opa = 16'hAAAA; opb = 16'h5555; cin = 1'b1;
      tick();
    end
    start = 1'b0;
    chk("ign_done_count", ndone, 1);
    chk("ign_result", result, 16'h0100);
    chk("ign_busy_idle", busy, 0);

    // Reset in the second RUN cycle: immediate reset values, never a done.
    op_code = 2'b10; opa = 16'h1234; opb = 16'h1111; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 16'h0000);
    chk("mid_rst_zero", zero, 1);
    chk("mid_rst_cout", c_out, 0);
    ndone = 0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("mid_rst_no_done", ndone, 0);

`ifdef ALU_SEQ_OVF_EN
    run_op(1'b0, 2'b10, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("ovf_result", result, 16'h8000);
    chk("ovf_set", ovf, 1);
    tick();
    run_op(1'b0, 2'b10, 16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("ovf_clear", ovf, 0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
Multi-nibble sequencer that sits directly upstream of the 4-bit alu and consumes its outputs. It accepts a W = 4*NIBBLES bit operation and feeds the alu one nibble per cycle, LSB nibble first. It chains c_out back into c_in for arithmetic ops and assembles the full-width result, carry and zero flags. The alu stays a separate instance; this block drives its A, B, c_in, ALUOP and l inputs and reads R, c_out and zero.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; W = 4*NIBBLES; legal values 1..8.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op_l  in  1  l for the whole operation (0 = arithmetic, 1 = logic)
op_code  in  2  ALUOP for the whole operation
cin  in  1  carry into nibble 0
opa  in  W  operand A
opb  in  W  operand B
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when the result is valid
result  out  W  assembled result, held until the next accepted start
c_out  out  1  final carry (arithmetic only)
zero  out  1  high when result == 0
alu_a  out  4  to alu A
alu_b  out  4  to alu B
alu_cin  out  1  to alu c_in
alu_op  out  2  to alu ALUOP
alu_l  out  1  to alu l
alu_r  in  4  from alu R
alu_cout  in  1  from alu c_out
alu_zero  in  1  from alu zero

Behaviour:
- Reset: state = IDLE; busy, done, c_out = 0; result = 0; zero = 1; idx = 0; carry_r = 0; operand registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start = 1 at edge E0:
  - Latch opa, opb, op_l, op_code and cin.
  - Set idx = 0 and go to RUN.
  - Clear the zero accumulator (set it to 1).
- IDLE, start = 0: remain in IDLE.
- RUN, alu drive (combinational from registers):
  - alu_a = opa_r[4*idx+:4]; alu_b = opb_r[4*idx+:4].
  - alu_op = op_code_r; alu_l = op_l_r.
  - alu_cin: when op_l_r = 0, cin_r for idx = 0, else carry_r. When op_l_r = 1, alu_cin = 0.
- RUN, each edge:
  - result[4*idx+:4] <= alu_r.
  - carry_r <= alu_cout.
  - zero accumulator <= accumulator & alu_zero.
  - idx++.
- RUN exit: at the edge where idx = NIBBLES-1, go to DONE. That is edge E_NIBBLES.
  - c_out <= op_l_r ? 0 : alu_cout.
  - zero <= final accumulator.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at E0, done high in the cycle after edge E_NIBBLES. Throughput is one operation per NIBBLES+2 cycles.
- In IDLE and DONE the alu drive outputs hold nibble 0 of the latched operands, with alu_cin = 0.
- start in RUN or DONE is ignored. No queuing.
- Mid-operation changes on opa, opb, op_* or cin have no effect, since operands were latched at E0.
- result, c_out and zero change only during RUN. They are stable from done until the next E_NIBBLES.
- Reset asserted mid-RUN: immediate return to reset values. No done pulse.
- NIBBLES = 1: RUN lasts exactly one cycle. alu_cin = cin_r.
- Wrap-around: carry out of the top nibble appears only on c_out. result wraps modulo 2^W.

Optional Feature:
ALU_SEQ_OVF_EN
- Defined: adds output port ovf (1 bit), registered at E_NIBBLES.
  - ovf = ~op_l_r & (op_code_r == 2'b10) & (opa_r[W-1] == opb_r[W-1]) & (alu_r[3] != opa_r[W-1]).
  - This is signed overflow of A+B+cin.
  - ovf resets to 0 and is held like c_out.
- Undefined: no ovf port and no related logic.

Decomposition:
- Shared header alu_seq_defs.vh holds:
  - State encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - ALUOP constants, with ALU_ADD_AB = 2'b10.
  - NIBBLES range check macro.
- One sub-module is natural: nib_sel. It selects a 4-bit slice of a W-bit bus by idx and is instantiated twice, for alu_a and alu_b.

Test Plan:
- Bench: pairs the block with the team's alu instance, NIBBLES = 4.
- Reset: reset = 1 -> busy = 0, done = 0, result = 16'h0000, zero = 1, c_out = 0.
- Basic add: op_l = 0, op_code = 10, opa = 16'h00FF, opb = 16'h0001, cin = 0, start -> busy for 4 cycles; done in cycle 5; result = 16'h0100; c_out = 0; zero = 0.
- Full wrap: opa = 16'hFFFF, opb = 16'h0001, cin = 0, add -> result = 16'h0000, c_out = 1, zero = 1. Separately, opa = 16'h1234, opb = 16'h1111, cin = 1 -> result = 16'h2346.
- Logic op: op_l = 1, any op_code -> alu_cin = 0 on every RUN cycle; c_out = 0; each result nibble equals the alu's 4-bit logic output for that slice.
- Ignored start: start pulsed in RUN and in DONE with different operands -> ignored; exactly one done; result unchanged. Reset asserted at the 2nd RUN cycle -> no done pulse; all outputs return to reset values.
- Overflow (ALU_SEQ_OVF_EN defined): opa = 16'h7FFF, opb = 16'h0001, cin = 0, add -> result = 16'h8000, ovf = 1. opa = 16'h0001, opb = 16'h0001 -> ovf = 0.
